decode: RTL and testbench

Second stage of the 3-stage pipeline. Consumes the opcode, operand fields and PC produced by the fetch stage. Decodes control, reads a 32x32 register file with write-back bypass, computes immediates and branch/jump targets, and registers everything into the execute-stage pipeline register. Also detects load-use hazards and requests a fetch stall.

---
 rtl/decode.sv | 179 +++++++++++++++++
 tb/tb_decode.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode.sv
// Decode stage: control decode, 2R/1W register file with write-back bypass,
// immediate/target generation, load-use hazard detection, execute pipeline register.
module decode #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [5:0]            instruction,
    input  logic [25:0]           operands,
    input  logic [31:0]           pc_decode,
    input  logic                  wb_en,
    input  logic [4:0]            wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  hazard_stall,
    output logic                  ex_valid,
    output logic [5:0]            ex_opcode,
    output logic [31:0]           ex_pc,
    output logic [DATA_WIDTH-1:0] ex_rs_val,
    output logic [DATA_WIDTH-1:0] ex_rt_val,
    output logic [31:0]           ex_imm,
    output logic [4:0]            ex_dest,
    output logic                  ex_wen,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_branch,
    output logic                  ex_jump,
    output logic [31:0]           ex_target,
    output logic                  illegal
);

    typedef enum logic [5:0] {
        OP_NOP  = 6'h00,
        OP_ADD  = 6'h01,
        OP_SUB  = 6'h02,
        OP_AND  = 6'h03,
        OP_OR   = 6'h04,
        OP_ADDI = 6'h05,
        OP_LW   = 6'h06,
        OP_SW   = 6'h07,
        OP_BEQ  = 6'h08,
        OP_J    = 6'h09
    } opcode_e;

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    logic [4:0]            w_rs, w_rt, w_rd;
    logic [15:0]           w_imm16;
    logic [31:0]           w_imm, w_target;
    logic [DATA_WIDTH-1:0] w_rs_val, w_rt_val;
    logic                  w_legal, w_real, w_reads_rs, w_reads_rt;
    logic                  w_mem_read, w_mem_write, w_branch, w_jump;
    logic [4:0]            w_dest;

    assign w_rs    = operands[25:21];
    assign w_rt    = operands[20:16];
    assign w_rd    = operands[15:11];
    assign w_imm16 = operands[15:0];
    assign w_imm   = {{16{w_imm16[15]}}, w_imm16};

    // r0 reads zero; a same-cycle write-back to the read index wins over the array
    always_comb begin
        w_rs_val = '0;
        w_rt_val = '0;
        if (w_rs != 5'd0)
            w_rs_val = (wb_en && wb_addr == w_rs) ? wb_data : r_regs[w_rs];
        if (w_rt != 5'd0)
            w_rt_val = (wb_en && wb_addr == w_rt) ? wb_data : r_regs[w_rt];
    end

    always_comb begin
        w_legal     = 1'b1;
        w_real      = 1'b0;
        w_reads_rs  = 1'b0;
        w_reads_rt  = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_branch    = 1'b0;
        w_jump      = 1'b0;
        w_dest      = '0;
        case (instruction)
            OP_NOP: ;
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                w_real     = 1'b1;
                w_dest     = w_rd;
                w_reads_rs = 1'b1;
                w_reads_rt = 1'b1;
            end
            OP_ADDI: begin
                w_real     = 1'b1;
                w_dest     = w_rt;
                w_reads_rs = 1'b1;
            end
            OP_LW: begin
                w_real     = 1'b1;
                w_dest     = w_rt;
                w_reads_rs = 1'b1;
                w_mem_read = 1'b1;
            end
            OP_SW: begin
                w_real      = 1'b1;
                w_reads_rs  = 1'b1;
                w_reads_rt  = 1'b1;
                w_mem_write = 1'b1;
            end
            OP_BEQ: begin
                w_real     = 1'b1;
                w_reads_rs = 1'b1;
                w_reads_rt = 1'b1;
                w_branch   = 1'b1;
            end
            OP_J: begin
                w_real = 1'b1;
                w_jump = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_target = '0;
        if (w_branch)
            w_target = pc_decode + 32'd4 + (w_imm << 2);
        else if (w_jump)
            w_target = {pc_decode[31:28], operands, 2'b00};
    end

    always_comb begin
        hazard_stall = !flush && ex_valid && ex_mem_read && (ex_dest != 5'd0) &&
                       ((w_reads_rs && w_rs == ex_dest) || (w_reads_rt && w_rt == ex_dest));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++)
                r_regs[i] <= '0;
        end else if (wb_en && wb_addr != 5'd0) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush || (!stall && (hazard_stall || !w_real))) begin
            ex_valid     <= 1'b0;
            ex_opcode    <= '0;
            ex_pc        <= '0;
            ex_rs_val    <= '0;
            ex_rt_val    <= '0;
            ex_imm       <= '0;
            ex_dest      <= '0;
            ex_wen       <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_branch    <= 1'b0;
            ex_jump      <= 1'b0;
            ex_target    <= '0;
            // only an undecodable word that actually reaches issue raises illegal
            illegal      <= !reset && !flush && !stall && !hazard_stall && !w_legal;
        end else if (!stall) begin
            ex_valid     <= 1'b1;
            ex_opcode    <= instruction;
            ex_pc        <= pc_decode;
            ex_rs_val    <= w_rs_val;
            ex_rt_val    <= w_rt_val;
            ex_imm       <= w_imm;
            ex_dest      <= w_dest;
            ex_wen       <= (w_dest != 5'd0);
            ex_mem_read  <= w_mem_read;
            ex_mem_write <= w_mem_write;
            ex_branch    <= w_branch;
            ex_jump      <= w_jump;
            ex_target    <= w_target;
            illegal      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode.sv
// Bench for decode: directed literal checks plus randomized traffic compared
// every cycle against a spec-level model of the register file and execute register.
module tb_decode;

    logic        clock = 1'b0;
    logic        reset, stall, flush, wb_en;
    logic [5:0]  instruction;
    logic [25:0] operands;
    logic [31:0] pc_decode, wb_data;
    logic [4:0]  wb_addr;
    logic        hazard_stall, ex_valid, ex_wen, ex_mem_read, ex_mem_write;
    logic        ex_branch, ex_jump, illegal;
    logic [5:0]  ex_opcode;
    logic [31:0] ex_pc, ex_rs_val, ex_rt_val, ex_imm, ex_target;
    logic [4:0]  ex_dest;

    localparam logic [5:0] NOP = 6'd0, ADD = 6'd1, SUB = 6'd2, ADDI = 6'd5,
                           LW = 6'd6, BEQ = 6'd8, JMP = 6'd9;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clock = ~clock;

    decode #(.DATA_WIDTH(32), .NUM_REGS(32)) dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .instruction(instruction), .operands(operands), .pc_decode(pc_decode),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
        .ex_pc(ex_pc), .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val), .ex_imm(ex_imm),
        .ex_dest(ex_dest), .ex_wen(ex_wen), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_jump(ex_jump),
        .ex_target(ex_target), .illegal(illegal)
    );

    typedef struct packed {
        logic        valid;
        logic [5:0]  op;
        logic [31:0] pc, rs, rt, imm;
        logic [4:0]  dest;
        logic        wen, mr, mw, br, j;
        logic [31:0] tgt;
        logic        ill;
    } ex_t;

    ex_t         m = '0;
    logic [31:0] mregs [32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_model(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wb_en && wb_addr == a) return wb_data;
        return mregs[a];
    endfunction

    function automatic bit reads_reg(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [4:0] r);
        case (op)
            6'd1, 6'd2, 6'd3, 6'd4, 6'd7, 6'd8: return (rs == r) || (rt == r);
            6'd5, 6'd6:                         return rs == r;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic bit model_hazard();
        return !flush && m.valid && m.mr && m.dest != 5'd0 &&
               reads_reg(instruction, operands[25:21], operands[20:16], m.dest);
    endfunction

    task automatic model_step();
        logic [31:0] a, b;
        bit          hz;
        a  = rd_model(operands[25:21]);
        b  = rd_model(operands[20:16]);
        hz = model_hazard();
        if (reset) begin
            m = '0;
            for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        end else begin
            if (wb_en && wb_addr != 5'd0) mregs[wb_addr] = wb_data;
            if (flush) m = '0;
            else if (!stall) begin
                if (hz || instruction == NOP) m = '0;
                else if (instruction > 6'd9) begin
                    m = '0;
                    m.ill = 1'b1;
                end else begin
                    m.valid = 1'b1;
                    m.op    = instruction;
                    m.pc    = pc_decode;
                    m.rs    = a;
                    m.rt    = b;
                    m.imm   = {{16{operands[15]}}, operands[15:0]};
                    if (instruction <= 6'd4)      m.dest = operands[15:11];
                    else if (instruction <= 6'd6) m.dest = operands[20:16];
                    else                          m.dest = 5'd0;
                    m.wen = m.dest != 5'd0;
                    m.mr  = instruction == 6'd6;
                    m.mw  = instruction == 6'd7;
                    m.br  = instruction == 6'd8;
                    m.j   = instruction == 6'd9;
                    if (m.br)     m.tgt = pc_decode + 32'd4 + (m.imm << 2);
                    else if (m.j) m.tgt = {pc_decode[31:28], operands, 2'b00};
                    else          m.tgt = 32'd0;
                    m.ill = 1'b0;
                end
            end
        end
    endtask

    always @(posedge clock) model_step();

    always @(negedge clock) begin
        if (chk_en) begin
            check("hazard_stall", 32'(hazard_stall), 32'(model_hazard()));
            check("ex_valid", 32'(ex_valid), 32'(m.valid));
            check("illegal", 32'(illegal), 32'(m.ill));
            check("ex_wen", 32'(ex_wen), 32'(m.wen));
            check("ex_mem_read", 32'(ex_mem_read), 32'(m.mr));
            check("ex_mem_write", 32'(ex_mem_write), 32'(m.mw));
            check("ex_branch", 32'(ex_branch), 32'(m.br));
            check("ex_jump", 32'(ex_jump), 32'(m.j));
            if (m.valid) begin
                check("ex_opcode", 32'(ex_opcode), 32'(m.op));
                check("ex_pc", ex_pc, m.pc);
                check("ex_rs_val", ex_rs_val, m.rs);
                check("ex_rt_val", ex_rt_val, m.rt);
                check("ex_imm", ex_imm, m.imm);
                check("ex_dest", 32'(ex_dest), 32'(m.dest));
                check("ex_target", ex_target, m.tgt);
            end
        end
    end

    function automatic logic [25:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd);
        return {rs, rt, rd, 11'd0};
    endfunction

    function automatic logic [25:0] itype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [15:0] imm);
        return {rs, rt, imm};
    endfunction

    task automatic drive(input logic [5:0] op, input logic [25:0] opr, input logic [31:0] pc);
        instruction = op;
        operands    = opr;
        pc_decode   = pc;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_1234;
        drive(ADD, rtype(5'd5, 5'd5, 5'd5), 32'h0);
        tick();
        chk_en = 1'b1;
        tick();
        check("reset_valid", 32'(ex_valid), 32'd0);
        check("reset_illegal", 32'(illegal), 32'd0);
        check("reset_target", ex_target, 32'd0);
        check("reset_hazard", 32'(hazard_stall), 32'd0);

        reset = 1'b0; wb_en = 1'b0;
        drive(ADD, rtype(5'd5, 5'd0, 5'd1), 32'h40);
        tick();
        check("r5_after_reset", ex_rs_val, 32'd0);

        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h0000_0010;
        drive(ADD, rtype(5'd3, 5'd0, 5'd4), 32'h44);
        tick();
        wb_en = 1'b0;
        check("bypass_rs", ex_rs_val, 32'h10);
        check("bypass_rt", ex_rt_val, 32'h0);
        check("bypass_dest", 32'(ex_dest), 32'd4);
        check("bypass_wen", 32'(ex_wen), 32'd1);

        drive(ADDI, itype(5'd0, 5'd2, 16'hFFFC), 32'h100);
        tick();
        check("addi_imm", ex_imm, 32'hFFFF_FFFC);
        drive(BEQ, itype(5'd0, 5'd0, 16'hFFFF), 32'h100);
        tick();
        check("beq_target", ex_target, 32'h100);
        drive(JMP, 26'h40, 32'hA000_0000);
        tick();
        check("j_target", ex_target, 32'hA000_0100);

        drive(LW, itype(5'd0, 5'd7, 16'h0), 32'h200);
        tick();
        drive(ADD, rtype(5'd7, 5'd0, 5'd9), 32'h204);
        #1;
        check("loaduse_hazard", 32'(hazard_stall), 32'd1);
        tick();
        check("loaduse_bubble", 32'(ex_valid), 32'd0);
        check("loaduse_released", 32'(hazard_stall), 32'd0);
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'hDEAD_BEEF;
        tick();
        wb_en = 1'b0;
        check("loaduse_issue", 32'(ex_valid), 32'd1);
        check("loaduse_value", ex_rs_val, 32'hDEAD_BEEF);

        drive(LW, itype(5'd0, 5'd7, 16'h0), 32'h300);
        tick();
        drive(ADD, rtype(5'd8, 5'd8, 5'd10), 32'h304);
        #1;
        check("indep_no_hazard", 32'(hazard_stall), 32'd0);
        tick();
        check("indep_issue", 32'(ex_valid), 32'd1);

        drive(6'h3F, 26'd0, 32'h400);
        tick();
        check("illegal_pulse", 32'(illegal), 32'd1);
        check("illegal_bubble", 32'(ex_valid), 32'd0);
        drive(NOP, 26'd0, 32'h404);
        tick();
        check("illegal_clears", 32'(illegal), 32'd0);
        drive(6'h3F, 26'd0, 32'h408);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("illegal_flushed", 32'(illegal), 32'd0);

        drive(ADD, rtype(5'd1, 5'd2, 5'd11), 32'h500);
        tick();
        stall = 1'b1;
        drive(SUB, rtype(5'd3, 5'd4, 5'd12), 32'h600);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold_dest", 32'(ex_dest), 32'd11);
            check("stall_hold_pc", ex_pc, 32'h500);
        end
        flush = 1'b1;
        tick();
        check("stall_flush", 32'(ex_valid), 32'd0);
        stall = 1'b0; flush = 1'b0;

        for (int k = 0; k < 2000; k++) begin
            logic [3:0] sel;
            sel   = 4'($urandom_range(0, 15));
            reset = ($urandom_range(0, 99) == 0);
            flush = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 5) == 0);
            wb_en = $urandom_range(0, 1) == 1;
            wb_addr = 5'($urandom_range(0, 7));
            wb_data = $urandom;
            if (sel < 4'd10)      instruction = 6'(sel);
            else if (sel < 4'd13) instruction = LW;
            else                  instruction = 6'($urandom);
            operands = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                        5'($urandom_range(0, 7)), 11'($urandom)};
            pc_decode = $urandom;
            tick();
        end

        reset = 1'b0; stall = 1'b0; flush = 1'b0; wb_en = 1'b0;
        drive(NOP, 26'd0, 32'h0);
        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
